// File: rtl/cm0_regbank.sv
// -----------------------------------------------------------------------------
// cm0_regbank
// Core register file for the Cortex-M0 datapath, plus a register-list sequencer
// for PUSH/POP/LDM/STM.
//
// Register file
//   R0-R12, banked MSP/PSP at index 13 (selected by spsel), LR, PC, and the
//   APSR/IPSR/PRIMASK status registers. Three combinational read ports with
//   same-cycle forwarding from two write ports. Port 0 has priority over port 1.
//   Writes to SP clear bits [1:0]; writes to PC clear bit 0.
//
// List sequencer
//   Walks a 16-bit register mask one element per accepted cycle, always in
//   ascending register order, lowest register at the lowest address. For
//   decrement-before the walk starts at base - N*step, so PUSH and POP share
//   one ascending walk. ls_wb holds the final base write-back value.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   ra/rb/rc_addr -> ra/rb/rc_data   read ports (combinational, forwarded)
//   w0_*, w1_*                   write ports (0 = ALU, 1 = load / write-back)
//   spsel                        0 = MSP, 1 = PSP at index 13
//   apsr_*, ipsr_*, pm_*         status register writes / current values
//   ls_start/mask/base/dec/ready sequencer control
//   ls_valid/idx/addr/busy/done/wb   sequencer outputs
// -----------------------------------------------------------------------------
module cm0_regbank #(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   RST_LR   = '1,
  parameter logic [5:0]      RST_IPSR = 6'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ra_addr,
  input  logic [3:0]    rb_addr,
  input  logic [3:0]    rc_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic [DW-1:0] rc_data,
  input  logic          w0_en,
  input  logic [3:0]    w0_addr,
  input  logic [DW-1:0] w0_data,
  input  logic          w1_en,
  input  logic [3:0]    w1_addr,
  input  logic [DW-1:0] w1_data,
  input  logic          spsel,
  input  logic          apsr_we,
  input  logic [3:0]    apsr_in,
  input  logic          ipsr_we,
  input  logic [5:0]    ipsr_in,
  input  logic          pm_we,
  input  logic          pm_in,
  output logic [3:0]    apsr,
  output logic [5:0]    ipsr,
  output logic          primask,
  input  logic          ls_start,
  input  logic [15:0]   ls_mask,
  input  logic [DW-1:0] ls_base,
  input  logic          ls_dec,
  input  logic          ls_ready,
  output logic          ls_valid,
  output logic [3:0]    ls_idx,
  output logic [DW-1:0] ls_addr,
  output logic          ls_busy,
  output logic          ls_done,
  output logic [DW-1:0] ls_wb
);

  localparam logic [DW-1:0] STEP = DW'(DW / 8);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] f_wmask(input logic [3:0] addr,
                                            input logic [DW-1:0] data);
    logic [DW-1:0] v;
    v = data;
    if (addr == 4'd13)      v[1:0] = 2'b00;
    else if (addr == 4'd15) v[0]   = 1'b0;
    return v;
  endfunction

  function automatic logic [DW-1:0] f_fwd(input logic [3:0]    addr,
                                          input logic [DW-1:0] stored,
                                          input logic          en0,
                                          input logic [3:0]    a0,
                                          input logic [DW-1:0] d0,
                                          input logic          en1,
                                          input logic [3:0]    a1,
                                          input logic [DW-1:0] d1);
    if (en0 && a0 == addr)      return d0;
    else if (en1 && a1 == addr) return d1;
    else                        return stored;
  endfunction

  function automatic logic [4:0] f_popcount(input logic [15:0] m);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(m[i]);
    return cnt;
  endfunction

  function automatic logic [3:0] f_lowest(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file. r_regs[13] is MSP; PSP lives in r_psp.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_regs [16];
  logic [DW-1:0] r_psp;
  logic [3:0]    r_apsr;
  logic [5:0]    r_ipsr;
  logic          r_primask;

  logic [DW-1:0] w_w0_data, w_w1_data;
  logic [DW-1:0] w_view [16];

  assign w_w0_data = f_wmask(w0_addr, w0_data);
  assign w_w1_data = f_wmask(w1_addr, w1_data);

  always_comb begin
    w_view     = r_regs;
    w_view[13] = spsel ? r_psp : r_regs[13];
  end

  assign ra_data = f_fwd(ra_addr, w_view[ra_addr], w0_en, w0_addr, w_w0_data,
                         w1_en, w1_addr, w_w1_data);
  assign rb_data = f_fwd(rb_addr, w_view[rb_addr], w0_en, w0_addr, w_w0_data,
                         w1_en, w1_addr, w_w1_data);
  assign rc_data = f_fwd(rc_addr, w_view[rc_addr], w0_en, w0_addr, w_w0_data,
                         w1_en, w1_addr, w_w1_data);

  // NOTE: the whole array is reset because architectural state has defined
  // reset values; port 1 is applied before port 0 so that, with non-blocking
  // assignments, port 0's update is the one that lands on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= (i == 14) ? RST_LR : '0;
      r_psp     <= '0;
      r_apsr    <= '0;
      r_ipsr    <= RST_IPSR;
      r_primask <= 1'b0;
    end else begin
      if (w1_en) begin
        if (w1_addr == 4'd13 && spsel) r_psp <= w_w1_data;
        else                           r_regs[w1_addr] <= w_w1_data;
      end
      if (w0_en) begin
        if (w0_addr == 4'd13 && spsel) r_psp <= w_w0_data;
        else                           r_regs[w0_addr] <= w_w0_data;
      end
      if (apsr_we) r_apsr    <= apsr_in;
      if (ipsr_we) r_ipsr    <= ipsr_in;
      if (pm_we)   r_primask <= pm_in;
    end
  end

  assign apsr    = r_apsr;
  assign ipsr    = r_ipsr;
  assign primask = r_primask;

  // ---------------------------------------------------------------------------
  // Register-list sequencer
  // ---------------------------------------------------------------------------
  state_t        r_state, w_next_state;
  logic [15:0]   r_mask;
  logic [3:0]    r_idx;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wb;

  logic [15:0]   w_mask_rest;
  logic [DW-1:0] w_span;

  // Mask left once the current element is accepted.
  assign w_mask_rest = r_mask & ~(16'd1 << r_idx);
  // Total bytes covered by the list: N * DW/8.
  assign w_span      = DW'(f_popcount(ls_mask)) * STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (ls_start) w_next_state = (ls_mask == '0) ? S_DONE : S_RUN;
      S_RUN:  if (ls_ready && w_mask_rest == '0) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ls_valid = (r_state == S_RUN);
    ls_busy  = (r_state != S_IDLE);
    ls_done  = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_idx  <= '0;
      r_addr <= '0;
      r_wb   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ls_start) begin
            r_mask <= ls_mask;
            r_wb   <= ls_dec ? ls_base - w_span : ls_base + w_span;
            if (ls_mask != '0) begin
              // Decrement-before starts at the bottom of the block so the
              // walk is ascending in both directions.
              r_addr <= ls_dec ? ls_base - w_span : ls_base;
              r_idx  <= f_lowest(ls_mask);
            end
          end
        end
        S_RUN: begin
          if (ls_ready) begin
            r_mask <= w_mask_rest;
            r_addr <= r_addr + STEP;
            if (w_mask_rest != '0) r_idx <= f_lowest(w_mask_rest);
          end
        end
        default: ;
      endcase
    end
  end

  assign ls_idx  = r_idx;
  assign ls_addr = r_addr;
  assign ls_wb   = r_wb;

endmodule

// File: doc/cm0_regbank.md
# cm0_regbank

Parametrised successor to the core register file of the Cortex-M0 datapath. It holds R0–R12, banked stack pointers (MSP/PSP), LR, PC, xPSR and PRIMASK, with three read ports, two prioritised write ports and same-cycle write-to-read forwarding. It also contains a register-list sequencer that walks a PUSH/POP/LDM/STM register mask, one register per cycle, producing register index, memory address and final base write-back value. It sits between the decoder/control FSM and the ALU/load-store unit.

## Interface
- DW, default 32: data width; memory step per register is DW/8.
- RST_LR, default all ones: LR reset value.
- RST_IPSR, default 6'h00: IPSR reset value.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ra_addr, rb_addr, rc_addr  in  4 each  read addresses.
- ra_data, rb_data, rc_data  out  DW each  read data (combinational, forwarded).
- w0_en, w0_addr, w0_data  in  1/4/DW  write port 0 (ALU result).
- w1_en, w1_addr, w1_data  in  1/4/DW  write port 1 (load data / base write-back).
- spsel  in  1  0 selects MSP, 1 selects PSP for index 13.
- apsr_we, apsr_in  in  1/4  NZCV write.
- ipsr_we, ipsr_in  in  1/6  exception-number write.
- pm_we, pm_in  in  1/1  PRIMASK write.
- apsr, ipsr, primask  out  4/6/1  current status.
- ls_start  in  1  start list walk (ignored while busy).
- ls_mask  in  16  register list, bit i = register i.
- ls_base  in  DW  base address.
- ls_dec  in  1  1 = decrement-before (PUSH/STMDB), 0 = increment-after.
- ls_ready  in  1  load-store unit accepts current element.
- ls_valid  out  1  current element valid.
- ls_idx  out  4  current register index.
- ls_addr  out  DW  current memory address.
- ls_busy  out  1  sequencer not IDLE.
- ls_done  out  1  one-cycle pulse after final element.
- ls_wb  out  DW  base write-back value, held from start until next start.

## Operation
- Reset: R0–R12, MSP, PSP, PC = 0; LR = RST_LR; APSR = 0; IPSR = RST_IPSR; PRIMASK = 0. Sequencer IDLE; ls_valid, ls_busy, ls_done = 0; ls_idx = 0; ls_addr = 0; ls_wb = 0.
- Index 13 reads/writes MSP when spsel=0, PSP when spsel=1. Writes to 13 force bits [1:0] to 0. Writes to 15 force bit 0 to 0.
- Both ports writing same address in one cycle: port 0 wins. Different addresses: both written.
- Forwarding: a read address matching an enabled write port this cycle returns that write data (port 0 over port 1), after the SP/PC masking. Otherwise returns stored value.
- APSR, IPSR, PRIMASK writes independent; may coincide with register writes.
- Sequencer states: IDLE, RUN, DONE.
  - IDLE, ls_start, N = popcount(ls_mask) > 0: latch mask; ls_wb = ls_dec ? base − N·DW/8 : base + N·DW/8; first address = ls_dec ? base − N·DW/8 : base; ls_idx = lowest set bit; -> RUN.
  - IDLE, ls_start, mask = 0: ls_wb = base; -> DONE directly, no valid element.
  - RUN: ls_valid = 1. On ls_ready: clear current bit, ls_addr += DW/8, ls_idx = next lowest set bit; if none remain -> DONE. Without ls_ready, outputs hold.
  - DONE: ls_done = 1 for one cycle -> IDLE.
- Registers always visited ascending, lowest register at lowest address, for both ls_dec values.
- Address arithmetic modulo 2^DW; wrap-around permitted silently.
- rst mid-walk: immediate return to IDLE, element abandoned, no done pulse.

## Timing
- Read: zero latency, combinational from address and forwarding.
- Write: visible in stored value the cycle after posedge.
- ls_start to first ls_valid: 1 cycle. Each accepted element: 1 cycle. N elements with ls_ready held high: ls_busy high N+1 cycles, ls_done at cycle N+1 after start.
- Empty mask: ls_done one cycle after start.
- ls_start while busy: ignored, no state change.

## Test plan
- Reset then read all 16 indices -> 0 except LR = FFFFFFFF; apsr=0, ipsr=RST_IPSR, primask=0.
- spsel=0 write R13=0x2000_0003 -> reads 0x2000_0000; spsel=1 reads PSP=0; write PSP, toggle spsel, both values preserved.
- Same cycle w0 R5=0xAAAA, w1 R5=0x5555, ra_addr=5 -> ra_data=0xAAAA, stored R5=0xAAAA next cycle.
- PUSH mask=0x40F0 (R4–R7, LR), base=0x2000_0100, dec=1, ready high -> idx 4,5,6,7,14 at addr 0x..EC,F0,F4,F8,FC; ls_wb=0x2000_00EC; done at cycle 6.
- POP mask=0x8001, base=0x100, dec=0, ready toggled every other cycle -> idx 0@0x100, 15@0x104, outputs held while not ready, ls_wb=0x108.
- Mask=0 -> done one cycle after start, ls_valid never high, ls_wb=base; rst asserted mid-walk -> busy/valid drop immediately, no done.
